// File: rtl/imul_pkg.sv
// rtl/imul_pkg.sv - shared state encodings for the iterative multiplier
package imul_pkg;

  localparam int IMUL_STATE_W = 2;

  typedef enum logic [IMUL_STATE_W-1:0] {
    IMUL_IDLE = 2'd0,
    IMUL_CALC = 2'd1,
    IMUL_DONE = 2'd2
  } imul_state_e;

endpackage

// File: rtl/imul_iterative_labeled_if.sv
// rtl/imul_iterative_labeled_if.sv - request/response handshake bundle with domain label
interface imul_iterative_labeled_if #(
  parameter int p_nbits = 32
);
  logic               domain;
  logic               req_val;
  logic               req_rdy;
  logic [p_nbits-1:0] req_a;
  logic [p_nbits-1:0] req_b;
  logic               resp_val;
  logic               resp_rdy;
  logic               resp_domain;
  logic [p_nbits-1:0] resp_result;

  modport master (
    output domain, req_val, req_a, req_b, resp_rdy,
    input  req_rdy, resp_val, resp_domain, resp_result
  );

  modport slave (
    input  domain, req_val, req_a, req_b, resp_rdy,
    output req_rdy, resp_val, resp_domain, resp_result
  );
endinterface

// File: rtl/imul_iterative_dpath.sv
// rtl/imul_iterative_dpath.sv - shift-add datapath: operand/accumulator/step-counter registers
module imul_iterative_dpath #(
  parameter int p_nbits     = 32,
  parameter int p_cnt_nbits = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [p_nbits-1:0] req_a,
  input  logic [p_nbits-1:0] req_b,
  output logic [p_nbits-1:0] acc,
  output logic               b_is_zero,
  output logic               cnt_done
);

  logic [p_nbits-1:0]     a_q, a_d;
  logic [p_nbits-1:0]     b_q, b_d;
  logic [p_nbits-1:0]     acc_q, acc_d;
  logic [p_cnt_nbits-1:0] cnt_q, cnt_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load) begin
      a_d   = req_a;
      b_d   = req_b;
      acc_d = '0;
      cnt_d = '0;
    end else if (step) begin
      // carry out of the accumulator is dropped: only the low word is returned
      if (b_q[0]) acc_d = acc_q + a_q;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc       = acc_q;
  assign b_is_zero = (b_q == '0);
  assign cnt_done  = (cnt_q == p_cnt_nbits'(p_nbits));

endmodule

// File: rtl/imul_iterative_labeled.sv
// rtl/imul_iterative_labeled.sv - iterative multiplier control FSM with security-domain latch
module imul_iterative_labeled
  import imul_pkg::*;
#(
  parameter int p_nbits     = 32,
  parameter int p_cnt_nbits = 6
) (
  input  logic                                    clk,
  input  logic                                    reset,
  imul_iterative_labeled_if.slave                 bus
);

  imul_state_e        state_q, state_d;
  logic               dom_q, dom_d;
  logic               load, step;
  logic               b_is_zero, cnt_done;
  logic [p_nbits-1:0] acc;

  assign load = (state_q == IMUL_IDLE) && bus.req_val;
  assign step = (state_q == IMUL_CALC) && !b_is_zero && !cnt_done;

  imul_iterative_dpath #(
    .p_nbits     (p_nbits),
    .p_cnt_nbits (p_cnt_nbits)
  ) u_dpath (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .req_a     (bus.req_a),
    .req_b     (bus.req_b),
    .acc       (acc),
    .b_is_zero (b_is_zero),
    .cnt_done  (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IMUL_IDLE;
      dom_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dom_q   <= dom_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dom_d   = dom_q;
    case (state_q)
      IMUL_IDLE: if (bus.req_val) begin
        state_d = IMUL_CALC;
        dom_d   = bus.domain;
      end
      IMUL_CALC: if (b_is_zero || cnt_done) state_d = IMUL_DONE;
      IMUL_DONE: if (bus.resp_rdy) state_d = IMUL_IDLE;
      default:   state_d = IMUL_IDLE;
    endcase
  end

  always_comb begin
    bus.req_rdy     = (state_q == IMUL_IDLE);
    bus.resp_val    = (state_q == IMUL_DONE);
    bus.resp_result = acc;
    bus.resp_domain = dom_q;
  end

endmodule

// File: tb/tb_imul_iterative_labeled.sv
// tb/tb_imul_iterative_labeled.sv - randomized self-checking bench for imul_iterative_labeled
module tb_imul_iterative_labeled;
  localparam int NB = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  imul_iterative_labeled_if #(.p_nbits(NB)) bus ();

  imul_iterative_labeled #(.p_nbits(NB), .p_cnt_nbits(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [NB-1:0] ref_mul(input logic [NB-1:0] a, input logic [NB-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[NB-1:0];
  endfunction

  // CALC cycles: one to see b==0, or highest-set-bit index + 2
  function automatic int ref_lat(input logic [NB-1:0] b);
    int m;
    if (b == 0) return 1;
    m = 0;
    for (int i = 0; i < NB; i++) if (b[i]) m = i;
    return m + 2;
  endfunction

  task automatic do_op(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic d,
                       input int hold, output logic [NB-1:0] res, output logic rdom,
                       output int lat, output bit tmo);
    @(negedge clk);
    bus.req_a = a; bus.req_b = b; bus.domain = d; bus.req_val = 1'b1;
    bus.resp_rdy = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    bus.req_val = 1'b0;
    bus.domain  = ~d;
    lat = 0;
    while (!bus.resp_val && lat < 100) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    tmo  = !bus.resp_val;
    res  = bus.resp_result;
    rdom = bus.resp_domain;
    repeat (hold) @(negedge clk);
    bus.resp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.req_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_req_rdy got %b want 1", bus.req_rdy); end
    n_cmp++; if (bus.resp_val !== 1'b0) begin n_fail++; $display("FAIL reset_resp_val got %b want 0", bus.resp_val); end
    n_cmp++; if (bus.resp_result !== '0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.resp_result); end
    n_cmp++; if (bus.resp_domain !== 1'b0) begin n_fail++; $display("FAIL reset_domain got %b want 0", bus.resp_domain); end
  endtask

  task automatic test_directed();
    logic [NB-1:0] av[5] = '{32'd3, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [NB-1:0] bv[5] = '{32'd5, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
    logic [NB-1:0] ex[5] = '{32'd15, 32'h0, 32'h0, 32'h1, 32'h0};
    int            lx[5] = '{4, 1, 33, 33, 3};
    logic [NB-1:0] res; logic rdom; int lat; bit tmo;
    for (int i = 0; i < 5; i++) begin
      do_op(av[i], bv[i], 1'(i), 0, res, rdom, lat, tmo);
      n_cmp++; if (tmo) begin n_fail++; $display("FAIL dir%0d_timeout no resp_val within 100 cycles", i); end
      n_cmp++; if (res !== ex[i]) begin n_fail++; $display("FAIL dir%0d_result got %h want %h", i, res, ex[i]); end
      n_cmp++; if (lat != lx[i]) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, lx[i]); end
      n_cmp++; if (rdom !== 1'(i)) begin n_fail++; $display("FAIL dir%0d_domain got %b want %b", i, rdom, 1'(i)); end
    end
  endtask

  task automatic test_backpressure();
    int guard = 0;
    @(negedge clk);
    bus.req_a = 32'd7; bus.req_b = 32'd6; bus.domain = 1'b1; bus.req_val = 1'b1; bus.resp_rdy = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.req_val = 1'b0;
    while (!bus.resp_val && guard < 100) begin @(posedge clk); guard++; @(negedge clk); end
    // competing request while the result is held back
    bus.req_a = 32'd100; bus.req_b = 32'd100; bus.req_val = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (bus.resp_val !== 1'b1 || bus.resp_result !== 32'd42) begin
        n_fail++; $display("FAIL bp_hold c%0d got val=%b res=%0d want val=1 res=42", c, bus.resp_val, bus.resp_result);
      end
      n_cmp++; if (bus.req_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_req_rdy c%0d got %b want 0", c, bus.req_rdy); end
      @(negedge clk);
    end
    bus.req_val = 1'b0;
    bus.resp_rdy = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.resp_rdy = 1'b0;
    n_cmp++; if (bus.req_rdy !== 1'b1 || bus.resp_val !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got rdy=%b val=%b want rdy=1 val=0", bus.req_rdy, bus.resp_val);
    end
  endtask

  task automatic test_reset_mid();
    logic [NB-1:0] res; logic rdom; int lat; bit tmo; bit seen = 0;
    @(negedge clk);
    bus.req_a = 32'd9; bus.req_b = 32'd9; bus.domain = 1'b1; bus.req_val = 1'b1; bus.resp_rdy = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.req_val = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    n_cmp++; if (bus.req_rdy !== 1'b1 || bus.resp_val !== 1'b0 || bus.resp_result !== '0) begin
      n_fail++; $display("FAIL rst_mid got rdy=%b val=%b res=%h want 1 0 0", bus.req_rdy, bus.resp_val, bus.resp_result);
    end
    for (int c = 0; c < 12; c++) begin @(negedge clk); if (bus.resp_val) seen = 1; end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL rst_mid_ghost got resp_val=1 want 0 after abandoned op"); end
    bus.resp_rdy = 1'b0;
    do_op(32'd2, 32'd2, 1'b0, 0, res, rdom, lat, tmo);
    n_cmp++; if (tmo || res !== 32'd4) begin n_fail++; $display("FAIL rst_after_op got %0d want 4", res); end
  endtask

  task automatic test_back_to_back();
    logic [NB-1:0] r1, r2; logic d1, d2; int l1, l2; bit t1, t2;
    do_op(32'd2, 32'd3, 1'b1, 0, r1, d1, l1, t1);
    do_op(32'd4, 32'd5, 1'b0, 0, r2, d2, l2, t2);
    n_cmp++; if (t1 || r1 !== 32'd6) begin n_fail++; $display("FAIL b2b_first got %0d want 6", r1); end
    n_cmp++; if (t2 || r2 !== 32'd20) begin n_fail++; $display("FAIL b2b_second got %0d want 20", r2); end
    n_cmp++; if (d1 !== 1'b1 || d2 !== 1'b0) begin n_fail++; $display("FAIL b2b_domain got %b%b want 10", d1, d2); end
  endtask

  task automatic test_random();
    logic [NB-1:0] a, b, res; logic d, rdom; int lat; bit tmo;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ((i % 8) == 0) b = '0;
      d = 1'($urandom);
      do_op(a, b, d, $urandom_range(0, 3), res, rdom, lat, tmo);
      n_cmp++; if (tmo || res !== ref_mul(a, b) || rdom !== d || lat != ref_lat(b)) begin
        n_fail++;
        $display("FAIL rand%0d a=%h b=%h got res=%h dom=%b lat=%0d want res=%h dom=%b lat=%0d",
                 i, a, b, res, rdom, lat, ref_mul(a, b), d, ref_lat(b));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.req_val = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.domain = 1'b0; bus.resp_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imul_iterative_labeled.md
# imul_iterative_labeled

Iterative shift-add integer multiplier with val/rdy request and response handshakes and security-domain tracking. It sits directly downstream of the operand muxes and sign/zero extenders and feeds the writeback mux. Its datapath reuses the adder, left/right logical shifters and zero comparator from the arithmetic component library. It returns the low p_nbits of the unsigned product and exits early once the remaining multiplier bits are zero.

## Interface
- p_nbits, 32, operand and result width (≥ 2)
- p_cnt_nbits, 6, step-counter width, ≥ clog2(p_nbits)+1
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low: reset==0 at a rising edge resets; one clock; reset is synchronous and active-low
- domain  in  1  {L} security domain of the incoming request
- req_val  in  1  request valid
- req_rdy  out  1  block can accept a request
- req_a  in  p_nbits  {Domain domain} multiplicand
- req_b  in  p_nbits  {Domain domain} multiplier
- resp_val  out  1  result valid
- resp_rdy  in  1  consumer accepts result
- resp_domain  out  1  {L} domain latched at request accept
- resp_result  out  p_nbits  {Domain resp_domain} low p_nbits of a*b

## Operation
- States: IDLE, CALC, DONE (2-bit encoding, IDLE=0).
- IDLE:
  - req_rdy=1, resp_val=0.
  - On req_val & req_rdy: a_reg←req_a, b_reg←req_b, acc←0, cnt←0, dom_reg←domain; go to CALC.
- CALC (req_rdy=0, resp_val=0), once per cycle:
  - If b_reg==0 or cnt==p_nbits: go to DONE with no datapath update.
  - Otherwise: if b_reg[0], acc←acc+a_reg (mod 2^p_nbits, carry discarded); a_reg←a_reg<<1; b_reg←b_reg>>1; cnt←cnt+1.
- DONE:
  - resp_val=1, req_rdy=0; resp_result=acc and resp_domain=dom_reg, both held stable.
  - On resp_rdy: go to IDLE.
- No DONE→CALC bypass: a new request is accepted only in IDLE.
- domain is sampled only at accept. Changes to domain while busy have no effect on the in-flight operation or on resp_domain.
- Arithmetic:
  - Unsigned; result equals (a*b) mod 2^p_nbits.
  - Signed callers get the correct low word because two's-complement low-word products are sign-agnostic.
- Reset (reset==0 at an edge):
  - State←IDLE; acc, a_reg, b_reg, cnt, dom_reg ←0.
  - Outputs after reset: req_rdy=1, resp_val=0, resp_result=0, resp_domain=0.
  - Reset mid-CALC or mid-DONE abandons the operation silently; no response is ever produced for it.
- req_val is ignored outside IDLE; no queuing.

## Timing
- Accept at edge E0. Let m be the index of the highest set bit of b (b≠0).
- CALC occupies m+2 cycles for b≠0 and 1 cycle for b=0.
- resp_val first rises in cycle E0+k+1, where k is the CALC cycle count.
  - Minimum latency: 2 cycles (b=0).
  - Maximum latency: p_nbits+2 cycles (b[p_nbits-1]=1).
- Response transfers on the edge where resp_val & resp_rdy. req_rdy is high in the following cycle.
- Back-to-back throughput: one operation per k+2 cycles.
- All outputs are registered-state decodes; there are no combinational paths from req_val or resp_rdy to any output.

## Structure
- Shared package imul_pkg: state encodings IMUL_IDLE/IMUL_CALC/IMUL_DONE, state width constant.
- One natural sub-module, imul_iterative_dpath:
  - Contains the a/b/acc/cnt registers, adder, two shifters, zero comparator and counter incrementer.
  - Exports b_is_zero and cnt_done to the control FSM, which stays in this top module.
  - All datapath sub-instances receive dom_reg as their domain input.

## Test plan
- 3×5, resp_rdy=1 → resp_result=15, resp_domain=domain at accept; CALC=4 cycles; resp_val at E0+5.
- 0x1234×0 → resp_result=0, resp_val at E0+2. Then 0×0xFFFF_FFFF → 0 after 34 cycles (33 CALC).
- 0xFFFF_FFFF×0xFFFF_FFFF → 0x0000_0001; 0x8000_0000×2 → 0 (overflow discarded).
- Backpressure: 7×6 with resp_rdy held low 10 cycles → resp_val and resp_result=42 stable throughout. A second req_val asserted meanwhile is not accepted (req_rdy=0).
- Reset: assert reset low during CALC of 9×9 → next cycle req_rdy=1, resp_val=0, resp_result=0. A following 2×2 returns 4 with no stale 81.
- Domain: accept with domain=1, flip domain to 0 during CALC → resp_domain=1. Back-to-back 2×3 then 4×5 with resp_rdy=1 → 6 then 20, in order.
